tinyalu_cmd_sequencer: RTL
==========================

# tinyalu_cmd_sequencer

Synthesizable command sequencer that sits between a command source and a TinyALU-class datapath. It buffers queued commands and drives the ALU start/op/A/B handshake, including a generated ALU reset for reset commands. It waits for `done` with a timeout and returns one response per command over a valid/ready channel. It generalises the ALU handshake to parametrised operand width, queue depth and timeout, and adds back-pressure, error reporting and status.

## Interface
- `DATA_W`, 8, operand width
- `RES_W`, 2*DATA_W, result width
- `DEPTH`, 4, command FIFO entries (power of 2, >=2)
- `TIMEOUT`, 255, max cycles from start to done before abort (>=2)
- `RST_CYC`, 2, cycles alu_reset_n is held low for rst_op
- `clk` in 1: single clock, all logic on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake; transfer when both are high.
- `cmd_a`, `cmd_b` in DATA_W: operands.
- `cmd_op` in 3: operation_t encoding.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_result` out RES_W: result.
- `rsp_op` out 3: echoed op.
- `rsp_status` out 2: status_t.
- `alu_a`, `alu_b` out DATA_W; `alu_op` out 3; `alu_start` out 1: ALU drive.
- `alu_done` in 1; `alu_result` in RES_W: ALU return.
- `alu_reset_n` out 1: generated ALU reset.
- `busy` out 1: FIFO non-empty or FSM not IDLE.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Encodings: no_op=0, add_op=1, and_op=2, xor_op=3, mul_op=4, rst_op=7. Codes 5 and 6 are illegal.
- Status values: ST_OK=0, ST_TIMEOUT=1, ST_ILLEGAL=2.
- FIFO: `cmd_ready = !full`. A push and a pop in the same cycle are allowed when full and leave `level` unchanged.
- FSM states: IDLE, ISSUE, WAIT, RESET, RESP.
- IDLE: if the FIFO is non-empty, pop into holding registers, then go to ISSUE.
- ISSUE: drive `alu_a/b/op` from the holding registers.
  - Illegal op: no ALU activity; status ST_ILLEGAL, result 0; go to RESP.
  - rst_op: go to RESET.
  - no_op: `alu_start` is high for exactly one cycle; result 0, ST_OK; go to RESP.
  - Any other op: `alu_start` goes high and the FSM moves to WAIT.
- WAIT: `alu_start` stays high and a cycle counter increments.
  - `alu_done` sampled high: capture `alu_result`, drop `alu_start` on the next edge, ST_OK, go to RESP.
  - Counter reaches TIMEOUT with no done: drop start, result 0, ST_TIMEOUT, go to RESP.
  - If done and timeout coincide, done wins.
- RESET: `alu_reset_n` is low and `alu_start` is low for RST_CYC cycles; then result 0, ST_OK, go to RESP.
- RESP: `rsp_valid` is high; result, op and status are held stable until `rsp_ready`, then go to IDLE.
- Ordering: exactly one response per accepted command, in acceptance order.
- `reset_n` low at any time, including mid-WAIT or mid-RESET: FIFO is emptied, FSM goes to IDLE, the in-flight command is discarded with no response.

## Timing
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_result`=0, `rsp_op`=0, `rsp_status`=0, `alu_a/b/op`=0, `alu_start`=0, `alu_reset_n`=1, `busy`=0, `level`=0.
- Command latency: command accepted at edge N (empty FIFO, IDLE) gives `alu_start` high after edge N+2.
- Response latency: `rsp_valid` rises one edge after done is sampled.
- `alu_a/b/op` are stable for the whole time `alu_start` is high.
- Back-to-back: a new ISSUE begins no earlier than one cycle after the RESP handshake, so `alu_start` is low for at least one cycle between commands.

## Structure
- Put operation_t, status_t and the ST_* constants in `tinyalu_pkg`.
- Sub-module `tinyalu_cmd_fifo`: parametrised on width and DEPTH, with count output and async reset.
- FSM, timeout counter and response registers live in the top module.

## Test plan
- add_op A=8'hFF, B=8'h01; ALU model returns done after 3 cycles with 16'h0100 -> response 16'h0100, ST_OK, op=1, with `alu_start` high exactly 3 cycles.
- Push 5 commands with DEPTH=4 and the ALU stalled -> `cmd_ready` low after 4 are buffered; all 5 responses arrive in order once the ALU runs.
- mul_op with done never asserted, TIMEOUT=10 -> `alu_start` drops after 10 cycles; response result 0, ST_TIMEOUT; the next command proceeds normally.
- rst_op then op=5 -> `alu_reset_n` low for exactly 2 cycles, ST_OK; second response ST_ILLEGAL with no `alu_start` pulse.
- `rsp_ready` held low for 20 cycles -> response fields stable throughout, no further ALU start.
- `reset_n` asserted mid-WAIT -> all outputs at reset values asynchronously, `level`=0, no stale response afterwards.

Source files
------------

// File: rtl/tinyalu_pkg.sv
// Shared encodings for the TinyALU command sequencer and its command FIFO.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'd0,
        add_op = 3'd1,
        and_op = 3'd2,
        xor_op = 3'd3,
        mul_op = 3'd4,
        rst_op = 3'd7
    } operation_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_ILLEGAL = 2'd2
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESET,
        S_RESP
    } seq_state_t;

    // Codes 5 and 6 have no ALU meaning.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op != 3'd5) && (op != 3'd6);
    endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// Circular command FIFO with occupancy count; push and pop may coincide even when full.
module tinyalu_cmd_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full     = (count_q == DEPTH[CW-1:0]);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // NOTE: storage has no reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/tinyalu_cmd_sequencer.sv
// Buffers commands, drives the TinyALU start/done handshake with timeout and
// generated ALU reset, and returns one response per command in order.
module tinyalu_cmd_sequencer
    import tinyalu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int RES_W   = 2 * DATA_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255,
    parameter int RST_CYC = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [DATA_W-1:0]      cmd_a,
    input  logic [DATA_W-1:0]      cmd_b,
    input  logic [2:0]             cmd_op,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [RES_W-1:0]       rsp_result,
    output logic [2:0]             rsp_op,
    output logic [1:0]             rsp_status,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [2:0]             alu_op,
    output logic                   alu_start,
    input  logic                   alu_done,
    input  logic [RES_W-1:0]       alu_result,
    output logic                   alu_reset_n,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam int FIFO_W  = 2 * DATA_W + 3;
    localparam int CNT_MAX = (TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    seq_state_t          state_q, state_d;
    logic [DATA_W-1:0]   hold_a_q, hold_a_d;
    logic [DATA_W-1:0]   hold_b_q, hold_b_d;
    logic [2:0]          hold_op_q, hold_op_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                start_q, start_d;
    logic                alu_rst_n_q, alu_rst_n_d;
    logic [RES_W-1:0]    rsp_result_q, rsp_result_d;
    logic [2:0]          rsp_op_q, rsp_op_d;
    status_t             rsp_status_q, rsp_status_d;

    logic                fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [FIFO_W-1:0]   fifo_wdata, fifo_rdata;

    assign fifo_push  = cmd_valid && cmd_ready;
    assign fifo_wdata = {cmd_op, cmd_a, cmd_b};

    tinyalu_cmd_fifo #(
        .W     (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (level)
    );

    assign cmd_ready   = !fifo_full;
    assign busy        = !fifo_empty || (state_q != S_IDLE);
    assign alu_a       = hold_a_q;
    assign alu_b       = hold_b_q;
    assign alu_op      = hold_op_q;
    assign alu_start   = start_q;
    assign alu_reset_n = alu_rst_n_q;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_result  = rsp_result_q;
    assign rsp_op      = rsp_op_q;
    assign rsp_status  = rsp_status_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d      = state_q;
        hold_a_d     = hold_a_q;
        hold_b_d     = hold_b_q;
        hold_op_d    = hold_op_q;
        cnt_d        = cnt_q;
        start_d      = start_q;
        alu_rst_n_d  = alu_rst_n_q;
        rsp_result_d = rsp_result_q;
        rsp_op_d     = rsp_op_q;
        rsp_status_d = rsp_status_q;
        fifo_pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop                       = 1'b1;
                    {hold_op_d, hold_a_d, hold_b_d} = fifo_rdata;
                    state_d                        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rsp_op_d     = hold_op_q;
                rsp_result_d = '0;
                rsp_status_d = ST_OK;
                if (!is_legal_op(hold_op_q)) begin
                    rsp_status_d = ST_ILLEGAL;
                    state_d      = S_RESP;
                end else if (hold_op_q == rst_op) begin
                    alu_rst_n_d = 1'b0;
                    cnt_d       = CNT_W'(1);
                    state_d     = S_RESET;
                end else if (hold_op_q == no_op) begin
                    // Single start pulse; RESP clears it on the following edge.
                    start_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    start_d = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (alu_done) begin
                    start_d      = 1'b0;
                    rsp_result_d = alu_result;
                    rsp_status_d = ST_OK;
                    state_d      = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    start_d      = 1'b0;
                    rsp_result_d = '0;
                    rsp_status_d = ST_TIMEOUT;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESET: begin
                if (cnt_q == CNT_W'(RST_CYC)) begin
                    alu_rst_n_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                start_d = 1'b0;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            hold_a_q     <= '0;
            hold_b_q     <= '0;
            hold_op_q    <= '0;
            cnt_q        <= '0;
            start_q      <= 1'b0;
            alu_rst_n_q  <= 1'b1;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
            rsp_status_q <= ST_OK;
        end else begin
            state_q      <= state_d;
            hold_a_q     <= hold_a_d;
            hold_b_q     <= hold_b_d;
            hold_op_q    <= hold_op_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            alu_rst_n_q  <= alu_rst_n_d;
            rsp_result_q <= rsp_result_d;
            rsp_op_q     <= rsp_op_d;
            rsp_status_q <= rsp_status_d;
        end
    end

endmodule
